// File: rtl/pc_cfr_pkg.sv
// Shared definitions for the peak-cancellation CFR pulse generator bank.
// Contents:
//   LATENCY     - edges from peak acceptance to CPW sample 0 on the cancel outputs
//   cpg_state_e - per-channel playback state
//   round_sat   - round-half-up, arithmetic shift and saturation to a signed word
package pc_cfr_pkg;

  localparam int unsigned LATENCY = 32'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } cpg_state_e;

  // The accumulator arrives sign-extended to 64 bits so one function serves
  // any data width. Adds 2**(dw-2), shifts right by dw-1, then clamps to the
  // signed dw-bit range. The caller keeps the low dw bits of the result.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned dw);
    logic signed [63:0] rounded;
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] result;
    rounded = acc + (64'sd1 <<< (dw - 32'd2));
    shifted = rounded >>> (dw - 32'd1);
    max_v   = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (dw - 32'd1));
    if (shifted > max_v) begin
      result = max_v;
    end else if (shifted < min_v) begin
      result = min_v;
    end else begin
      result = shifted;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_cfr_cpg_channel.sv
// One cancellation pulse generator channel.
// Holds a private copy of the CPW (written by the shared write port), an
// address FSM that walks the CPW once per allocation, the latched peak
// coefficient and a pipelined complex multiplier.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wr_en, wr_addr, wr_data_i/q     CPW write port (broadcast to all channels)
//   alloc                           start a pulse this edge (only when idle)
//   coef_i/q                        peak coefficient, latched on alloc
//   busy                            channel is playing
//   prod_i/q                        complex product, 0 when no valid sample
module pc_cfr_cpg_channel
  import pc_cfr_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CPW_ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CPW_ADDR_WIDTH-1:0]     wr_addr,
  input  logic signed [DATA_WIDTH-1:0]  wr_data_i,
  input  logic signed [DATA_WIDTH-1:0]  wr_data_q,
  input  logic                          alloc,
  input  logic signed [DATA_WIDTH-1:0]  coef_i,
  input  logic signed [DATA_WIDTH-1:0]  coef_q,
  output logic                          busy,
  output logic signed [2*DATA_WIDTH:0]  prod_i,
  output logic signed [2*DATA_WIDTH:0]  prod_q
);

  localparam int PW    = 2 * DATA_WIDTH + 1;
  localparam int DEPTH = 2 ** CPW_ADDR_WIDTH;
  localparam logic [CPW_ADDR_WIDTH-1:0] ADDR_MAX = {CPW_ADDR_WIDTH{1'b1}};

  cpg_state_e state_r;
  cpg_state_e state_nxt_s;

  logic [CPW_ADDR_WIDTH-1:0]    addr_r;
  logic signed [DATA_WIDTH-1:0] coef_i_r, coef_q_r;

  // Stage 1: read address issue
  logic                         v1_r;
  logic [CPW_ADDR_WIDTH-1:0]    rd_addr_r;
  logic signed [DATA_WIDTH-1:0] c1_i_r, c1_q_r;
  // Stage 2: RAM read data
  logic                         v2_r;
  logic signed [DATA_WIDTH-1:0] rd_i_r, rd_q_r;
  logic signed [DATA_WIDTH-1:0] c2_i_r, c2_q_r;
  // Stage 3: partial products
  logic                         v3_r;
  logic signed [2*DATA_WIDTH-1:0] pp_ii_r, pp_qq_r, pp_iq_r, pp_qi_r;
  // Stage 4: add/sub
  logic signed [PW-1:0]         prod_i_r, prod_q_r;

  logic signed [DATA_WIDTH-1:0] mem_i [DEPTH];
  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Playback state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: one full CPW sweep per allocation, no retrigger while playing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (alloc) begin
          state_nxt_s = PLAY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PLAY: begin
        if (addr_r == ADDR_MAX) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Address counter and coefficient latch; the counter wraps to 0 after the last address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r   <= {CPW_ADDR_WIDTH{1'b0}};
      coef_i_r <= {DATA_WIDTH{1'b0}};
      coef_q_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (state_r == PLAY) begin
        addr_r <= addr_r + CPW_ADDR_WIDTH'(1);
      end else begin
        addr_r <= {CPW_ADDR_WIDTH{1'b0}};
      end
      if (alloc && (state_r == IDLE)) begin
        coef_i_r <= coef_i;
        coef_q_r <= coef_q;
      end
    end
  end

  // CPW RAM copy: write port plus registered read (no reset so it maps to block RAM)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_i[wr_addr] <= wr_data_i;
      mem_q[wr_addr] <= wr_data_q;
    end
    rd_i_r <= mem_i[rd_addr_r];
    rd_q_r <= mem_q[rd_addr_r];
  end

  // Sample pipeline. The coefficient travels with each sample so a channel
  // reallocated right after finishing cannot rescale its own tail samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r      <= 1'b0;
      rd_addr_r <= {CPW_ADDR_WIDTH{1'b0}};
      c1_i_r    <= {DATA_WIDTH{1'b0}};
      c1_q_r    <= {DATA_WIDTH{1'b0}};
      v2_r      <= 1'b0;
      c2_i_r    <= {DATA_WIDTH{1'b0}};
      c2_q_r    <= {DATA_WIDTH{1'b0}};
      v3_r      <= 1'b0;
      pp_ii_r   <= {(2*DATA_WIDTH){1'b0}};
      pp_qq_r   <= {(2*DATA_WIDTH){1'b0}};
      pp_iq_r   <= {(2*DATA_WIDTH){1'b0}};
      pp_qi_r   <= {(2*DATA_WIDTH){1'b0}};
      prod_i_r  <= {PW{1'b0}};
      prod_q_r  <= {PW{1'b0}};
    end else begin
      v1_r      <= (state_r == PLAY);
      rd_addr_r <= addr_r;
      c1_i_r    <= coef_i_r;
      c1_q_r    <= coef_q_r;
      v2_r      <= v1_r;
      c2_i_r    <= c1_i_r;
      c2_q_r    <= c1_q_r;
      v3_r      <= v2_r;
      pp_ii_r   <= rd_i_r * c2_i_r;
      pp_qq_r   <= rd_q_r * c2_q_r;
      pp_iq_r   <= rd_i_r * c2_q_r;
      pp_qi_r   <= rd_q_r * c2_i_r;
      if (v3_r) begin
        prod_i_r <= PW'(pp_ii_r) - PW'(pp_qq_r);
        prod_q_r <= PW'(pp_iq_r) + PW'(pp_qi_r);
      end else begin
        prod_i_r <= {PW{1'b0}};
        prod_q_r <= {PW{1'b0}};
      end
    end
  end

  assign busy   = (state_r == PLAY);
  assign prod_i = prod_i_r;
  assign prod_q = prod_q_r;

endmodule

// File: rtl/pc_cfr_cpg.sv
// Cancellation pulse generator bank for the peak-cancellation CFR datapath.
// Allocates each accepted peak to the lowest-index idle channel, sums the
// channel products, rounds/saturates the sum and counts dropped peaks.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ctrl_enable                        accept new peaks when 1
//   ctrl_cpw_wr_en/_addr/_data_i/_q    CPW write port
//   peak_valid, peak_coef_i/_q         peak strobe and complex coefficient
//   cancel_i/_q                        summed cancellation sample
//   cpg_busy                           per-channel active flags
//   stat_drop_cnt                      saturating count of dropped peaks
module pc_cfr_cpg
  import pc_cfr_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CPW_ADDR_WIDTH = 8,
  parameter int NUM_CPG        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_enable,
  input  logic                         ctrl_cpw_wr_en,
  input  logic [CPW_ADDR_WIDTH-1:0]    ctrl_cpw_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] ctrl_cpw_wr_data_i,
  input  logic signed [DATA_WIDTH-1:0] ctrl_cpw_wr_data_q,
  input  logic                         peak_valid,
  input  logic signed [DATA_WIDTH-1:0] peak_coef_i,
  input  logic signed [DATA_WIDTH-1:0] peak_coef_q,
  output logic signed [DATA_WIDTH-1:0] cancel_i,
  output logic signed [DATA_WIDTH-1:0] cancel_q,
  output logic [NUM_CPG-1:0]           cpg_busy,
  output logic [15:0]                  stat_drop_cnt
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam int SW = PW + $clog2(NUM_CPG);

  logic [NUM_CPG-1:0]   busy_s;
  logic [NUM_CPG-1:0]   alloc_s;
  logic                 accept_s;
  logic                 found_s;
  logic                 drop_s;
  logic signed [PW-1:0] prod_i_s [NUM_CPG];
  logic signed [PW-1:0] prod_q_s [NUM_CPG];
  logic signed [SW-1:0] sum_i_s, sum_q_s;
  logic signed [SW-1:0] sum_i_r, sum_q_r;
  logic signed [DATA_WIDTH-1:0] cancel_i_r, cancel_q_r;
  logic [15:0]          drop_cnt_r;

  for (genvar c = 0; c < NUM_CPG; c++) begin : g_ch
    pc_cfr_cpg_channel #(
      .DATA_WIDTH    (DATA_WIDTH),
      .CPW_ADDR_WIDTH(CPW_ADDR_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (ctrl_cpw_wr_en),
      .wr_addr  (ctrl_cpw_wr_addr),
      .wr_data_i(ctrl_cpw_wr_data_i),
      .wr_data_q(ctrl_cpw_wr_data_q),
      .alloc    (alloc_s[c]),
      .coef_i   (peak_coef_i),
      .coef_q   (peak_coef_q),
      .busy     (busy_s[c]),
      .prod_i   (prod_i_s[c]),
      .prod_q   (prod_q_s[c])
    );
  end

  // Allocator: lowest-index idle channel wins; a channel finishing this edge is still busy
  always_comb begin
    alloc_s  = {NUM_CPG{1'b0}};
    found_s  = 1'b0;
    accept_s = peak_valid & ctrl_enable;
    for (int c = 0; c < NUM_CPG; c++) begin
      if (!found_s && !busy_s[c]) begin
        alloc_s[c] = accept_s;
        found_s    = 1'b1;
      end else begin
        alloc_s[c] = 1'b0;
      end
    end
    drop_s = accept_s & ~found_s;
  end

  // Channel summation; idle channels already present zero products
  always_comb begin
    sum_i_s = {SW{1'b0}};
    sum_q_s = {SW{1'b0}};
    for (int c = 0; c < NUM_CPG; c++) begin
      sum_i_s = sum_i_s + SW'(prod_i_s[c]);
      sum_q_s = sum_q_s + SW'(prod_q_s[c]);
    end
  end

  // Sum register, rounded/saturated output register and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_i_r    <= {SW{1'b0}};
      sum_q_r    <= {SW{1'b0}};
      cancel_i_r <= {DATA_WIDTH{1'b0}};
      cancel_q_r <= {DATA_WIDTH{1'b0}};
      drop_cnt_r <= 16'd0;
    end else begin
      sum_i_r    <= sum_i_s;
      sum_q_r    <= sum_q_s;
      cancel_i_r <= DATA_WIDTH'(round_sat(64'(sum_i_r), DATA_WIDTH));
      cancel_q_r <= DATA_WIDTH'(round_sat(64'(sum_q_r), DATA_WIDTH));
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign cancel_i      = cancel_i_r;
  assign cancel_q      = cancel_q_r;
  assign cpg_busy      = busy_s;
  assign stat_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pc_cfr_cpg.sv
module tb_pc_cfr_cpg;

  logic        clk;
  logic        rst_n;
  logic        ctrl_enable;
  logic        ctrl_cpw_wr_en;
  logic [7:0]  ctrl_cpw_wr_addr;
  logic [15:0] ctrl_cpw_wr_data_i;
  logic [15:0] ctrl_cpw_wr_data_q;
  logic        peak_valid;
  logic [15:0] peak_coef_i;
  logic [15:0] peak_coef_q;
  logic [15:0] cancel_i;
  logic [15:0] cancel_q;
  logic [3:0]  cpg_busy;
  logic [15:0] stat_drop_cnt;

  pc_cfr_cpg #(.DATA_WIDTH(16), .CPW_ADDR_WIDTH(8), .NUM_CPG(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_enable       (ctrl_enable),
    .ctrl_cpw_wr_en    (ctrl_cpw_wr_en),
    .ctrl_cpw_wr_addr  (ctrl_cpw_wr_addr),
    .ctrl_cpw_wr_data_i(ctrl_cpw_wr_data_i),
    .ctrl_cpw_wr_data_q(ctrl_cpw_wr_data_q),
    .peak_valid        (peak_valid),
    .peak_coef_i       (peak_coef_i),
    .peak_coef_q       (peak_coef_q),
    .cancel_i          (cancel_i),
    .cancel_q          (cancel_q),
    .cpg_busy          (cpg_busy),
    .stat_drop_cnt     (stat_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ACC_N = 8192;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;   // index of the most recent rising edge

  // Behavioural model: CPW contents, list of played pulses, per-edge expected sums
  int     m_cpw_i [256];
  int     m_cpw_q [256];
  int     p_start [64];
  int     p_ci    [64];
  int     p_cq    [64];
  int     n_p;
  int     ch_start[4];
  int     m_drop;
  longint acc_i [ACC_N];
  longint acc_q [ACC_N];
  longint exp_ci, exp_cq;
  int     exp_busy;

  function automatic longint rsat(input longint a);
    longint v;
    v = (a + 64'sd16384) >>> 15;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, expv);
    end
  endtask

  task automatic model_reset();
    n_p = 0;
    m_drop = 0;
    for (int c = 0; c < 4; c++) ch_start[c] = -1000;
    for (int i = 0; i < ACC_N; i++) begin
      acc_i[i] = 0;
      acc_q[i] = 0;
    end
    exp_ci = 0;
    exp_cq = 0;
    exp_busy = 0;
  endtask

  // A pulse started at edge s shows sample j on the output after edge s+6+j,
  // using the CPW word as it stood just before edge s+2+j.
  task automatic model_edge();
    int j;
    int found;
    for (int p = 0; p < n_p; p++) begin
      j = e - p_start[p] - 2;
      if (j >= 0 && j < 256 && e + 4 < ACC_N) begin
        acc_i[e+4] += longint'(m_cpw_i[j]) * p_ci[p] - longint'(m_cpw_q[j]) * p_cq[p];
        acc_q[e+4] += longint'(m_cpw_i[j]) * p_cq[p] + longint'(m_cpw_q[j]) * p_ci[p];
      end
    end
    if (ctrl_cpw_wr_en) begin
      m_cpw_i[ctrl_cpw_wr_addr] = int'($signed(ctrl_cpw_wr_data_i));
      m_cpw_q[ctrl_cpw_wr_addr] = int'($signed(ctrl_cpw_wr_data_q));
    end
    if (peak_valid && ctrl_enable) begin
      found = -1;
      // a channel is free again only after the edge on which it finishes
      for (int c = 0; c < 4; c++)
        if (found < 0 && e > ch_start[c] + 256) found = c;
      if (found >= 0) begin
        ch_start[found] = e;
        if (n_p < 64) begin
          p_start[n_p] = e;
          p_ci[n_p] = int'($signed(peak_coef_i));
          p_cq[n_p] = int'($signed(peak_coef_q));
          n_p++;
        end
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    exp_ci = rsat(acc_i[e]);
    exp_cq = rsat(acc_q[e]);
    exp_busy = 0;
    for (int c = 0; c < 4; c++)
      if (e >= ch_start[c] && e < ch_start[c] + 256) exp_busy |= (1 << c);
  endtask

  task automatic compare_all();
    check("cancel_i", longint'($signed(cancel_i)), exp_ci);
    check("cancel_q", longint'($signed(cancel_q)), exp_cq);
    check("cpg_busy", longint'(cpg_busy), longint'(exp_busy));
    check("drop_cnt", longint'(stat_drop_cnt), longint'(m_drop));
  endtask

  // One clock: advance the model on the edge, compare 1 ns after it
  task automatic tick();
    @(posedge clk);
    e++;
    if (rst_n) model_edge();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic run_until(input int target);
    while (e < target) tick();
  endtask

  task automatic cpw_write(input int a, input logic [15:0] di, input logic [15:0] dq);
    ctrl_cpw_wr_en     = 1'b1;
    ctrl_cpw_wr_addr   = 8'(a);
    ctrl_cpw_wr_data_i = di;
    ctrl_cpw_wr_data_q = dq;
    tick();
    ctrl_cpw_wr_en = 1'b0;
  endtask

  task automatic pulse_peak(input logic [15:0] ci, input logic [15:0] cq);
    peak_valid  = 1'b1;
    peak_coef_i = ci;
    peak_coef_q = cq;
    tick();
    peak_valid = 1'b0;
  endtask

  int k;
  int k2;

  initial begin
    rst_n = 1'b0;
    ctrl_enable = 1'b0;
    ctrl_cpw_wr_en = 1'b0;
    ctrl_cpw_wr_addr = 8'd0;
    ctrl_cpw_wr_data_i = 16'd0;
    ctrl_cpw_wr_data_q = 16'd0;
    peak_valid = 1'b0;
    peak_coef_i = 16'd0;
    peak_coef_q = 16'd0;
    for (int i = 0; i < 256; i++) begin
      m_cpw_i[i] = 0;
      m_cpw_q[i] = 0;
    end
    model_reset();
    repeat (3) tick();
    check("reset_cancel_i", longint'($signed(cancel_i)), 0);
    check("reset_busy", longint'(cpg_busy), 0);
    check("reset_drop", longint'(stat_drop_cnt), 0);
    rst_n = 1'b1;
    ctrl_enable = 1'b1;

    // Impulse: CPW[0]=(0.5,0), coef 0.5 -> 8192 exactly LATENCY edges later
    for (int a = 0; a < 256; a++) cpw_write(a, (a == 0) ? 16'h4000 : 16'h0000, 16'h0000);
    pulse_peak(16'h4000, 16'h0000);
    k = e;
    run_until(k + 5);
    check("impulse_early", longint'($signed(cancel_i)), 0);
    tick();
    check("impulse_k6_i", longint'($signed(cancel_i)), 8192);
    check("impulse_k6_q", longint'($signed(cancel_q)), 0);
    tick();
    check("impulse_after", longint'($signed(cancel_i)), 0);
    run_until(k + 260);

    // Complex: CPW[5]=(0.5,0.5), coef (0,0.5)
    cpw_write(0, 16'h0000, 16'h0000);
    cpw_write(5, 16'h4000, 16'h4000);
    pulse_peak(16'h0000, 16'h4000);
    k = e;
    run_until(k + 11);
    check("complex_i", longint'($signed(cancel_i)), -8192);
    check("complex_q", longint'($signed(cancel_q)), 8192);
    run_until(k + 262);

    // Saturation: two full-scale pulses overlap -> 65536 clipped to 32767
    cpw_write(5, 16'h0000, 16'h0000);
    cpw_write(0, 16'h8000, 16'h0000);
    cpw_write(1, 16'h8000, 16'h0000);
    pulse_peak(16'h8000, 16'h0000);
    k = e;
    pulse_peak(16'h8000, 16'h0000);
    check("sat_two_busy", longint'(cpg_busy), 3);
    run_until(k + 7);
    check("sat_clip", longint'($signed(cancel_i)), 32767);
    run_until(k + 262);

    // Disabled: peak ignored and not counted as a drop
    ctrl_enable = 1'b0;
    pulse_peak(16'h1000, 16'h0000);
    ctrl_enable = 1'b1;
    check("disabled_busy", longint'(cpg_busy), 0);
    check("disabled_drop", longint'(stat_drop_cnt), 0);

    // Exhaustion: five peaks back to back, the fifth is dropped
    peak_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      peak_coef_i = 16'(16'h0800 * (i + 1));
      peak_coef_q = 16'(16'h0400 * i);
      tick();
      if (i == 0) k = e;
    end
    peak_valid = 1'b0;
    check("exh_busy", longint'(cpg_busy), 15);
    check("exh_drop", longint'(stat_drop_cnt), 1);
    run_until(k + 255);
    check("exh_busy_k255", longint'(cpg_busy), 15);
    // channel 0 finishes on this edge and still refuses the peak
    pulse_peak(16'h0100, 16'h0000);
    check("exh_finish_drop", longint'(stat_drop_cnt), 2);
    check("exh_busy_k256", longint'(cpg_busy), 14);
    // next edge channel 0 is free, channel 1 finishes
    pulse_peak(16'h0100, 16'h0000);
    check("exh_realloc_busy", longint'(cpg_busy), 13);
    check("exh_realloc_drop", longint'(stat_drop_cnt), 2);
    run_until(k + 257 + 262);

    // Live rewrite: CPW[200] cleared while channel 0 plays a constant-1/2 CPW
    for (int a = 0; a < 256; a++) cpw_write(a, 16'h4000, 16'h0000);
    pulse_peak(16'h4000, 16'h0000);
    k = e;
    run_until(k + 99);
    cpw_write(200, 16'h0000, 16'h0000);
    run_until(k + 205);
    check("live_s199", longint'($signed(cancel_i)), 8192);
    tick();
    check("live_s200", longint'($signed(cancel_i)), 0);
    tick();
    check("live_s201", longint'($signed(cancel_i)), 8192);
    run_until(k + 262);

    // Reset at sample 100 of a pulse
    pulse_peak(16'h4000, 16'h0000);
    k = e;
    run_until(k + 106);
    check("rst_pre", longint'($signed(cancel_i)), 8192);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_cancel_i", longint'($signed(cancel_i)), 0);
    check("rst_cancel_q", longint'($signed(cancel_q)), 0);
    check("rst_busy", longint'(cpg_busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_post_idle", longint'($signed(cancel_i)), 0);
    pulse_peak(16'h4000, 16'h0000);
    k2 = e;
    run_until(k2 + 6);
    check("rst_cpw_s0", longint'($signed(cancel_i)), 8192);
    run_until(k2 + 206);
    check("rst_cpw_s200", longint'($signed(cancel_i)), 0);
    run_until(k2 + 262);
    check("final_busy", longint'(cpg_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
